dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width presented to the data RAM.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles to wait for ram_ack before error.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 Reset_n  input  1  reset; synchronous and active-low.
REQ-005 req_valid  input  1  memory-stage access request.
REQ-006 req_ready  output  1  block idle and able to accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_byte  input  1  1 = byte access (lb/sb), 0 = word access (lw/sw).
REQ-009 req_addr  input  32  byte address, the ALU result.
REQ-010 req_wdata  input  32  store data, the RF_B value.
REQ-011 rsp_valid  output  1  one-cycle pulse: access complete.
REQ-012 rsp_rdata  output  32  load result, valid while rsp_valid is high.
REQ-013 stall  output  1  hold PC and pipeline while high.
REQ-014 err  output  1  one-cycle pulse: misaligned access or timeout.
REQ-015 ram_req  output  1  RAM request, held until ram_ack.
REQ-016 ram_we  output  1  RAM write enable.
REQ-017 ram_addr  output  ADDR_W  word address, equal to req_addr[ADDR_W+1:2].
REQ-018 ram_be  output  4  byte enables; bit i selects bits [8i+7:8i].
REQ-019 ram_wdata  output  32  RAM write data.
REQ-020 ram_ack  input  1  RAM completion; read data valid in the same cycle.
REQ-021 ram_rdata  input  32  RAM read word.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge in IDLE with req_valid=1.
REQ-024 On acceptance, the block SHALL register addr, we, byte, wdata, be and lane; a legal request goes to ACCESS.
REQ-025 A word request with req_addr[1:0]!=0 SHALL be illegal: no RAM access, err=1 for one cycle, then IDLE, no rsp_valid.
REQ-026 In ACCESS, ram_req SHALL be 1 with stable ram_addr/ram_we/ram_be/ram_wdata until ram_ack is sampled 1.
REQ-027 Word access SHALL use ram_be=4'b1111 and ram_wdata=req_wdata.
REQ-028 Byte access SHALL use lane=req_addr[1:0], ram_be=1<<lane, and ram_wdata=req_wdata[7:0] replicated four times.
REQ-029 On ram_ack, the block SHALL register the read data and enter RESP; in RESP, rsp_valid=1 for exactly one cycle, then IDLE.
REQ-030 Word load SHALL give rsp_rdata=ram_rdata; byte load SHALL give {24'b0, selected lane byte} (zero-extend).
REQ-031 A store SHALL also pulse rsp_valid; rsp_rdata SHALL be 0.
REQ-032 Minimum latency SHALL be: accept at edge N, ram_ack in cycle N+1, rsp_valid in cycle N+2.
REQ-033 stall SHALL be combinational: (IDLE and req_valid) or ACCESS; stall=0 in RESP so the core advances.
REQ-034 A cycle counter SHALL clear on entry to ACCESS; when it reaches TIMEOUT without ram_ack, the block SHALL pulse err, drop ram_req and return to IDLE without rsp_valid.
REQ-035 If ram_ack arrives in the same cycle the counter reaches TIMEOUT, ram_ack SHALL win; no err.
REQ-036 ram_ack outside ACCESS SHALL be ignored.
REQ-037 req_valid in ACCESS or RESP SHALL be ignored (not queued).

Reset
REQ-038 On a clk edge with Reset_n=0, the state SHALL become IDLE and the counter 0.
REQ-039 After reset, outputs SHALL be: req_ready=1, rsp_valid, err, ram_req, ram_we = 0, and ram_be, ram_addr, ram_wdata, rsp_rdata = 0.
REQ-040 Reset during ACCESS SHALL drop ram_req on that edge and produce no rsp_valid or err.

Structure
REQ-041 Package dmem_pkg SHALL hold the state enum, the lane/byte-enable constants and the TIMEOUT default.
REQ-042 Sub-module byte_lane SHALL be combinational: lane+byte -> ram_be/ram_wdata, and lane+ram_rdata -> load data.

Verification
REQ-043 Case sw: addr=0x0000_0008, wdata=0xDEADBEEF, ack after 3 cycles -> ram_addr=2, be=1111, one rsp_valid, stall high 4 cycles.
REQ-044 Case lb: addr=0x0000_0006, ram_rdata=0x11223344, immediate ack -> be=0100, rsp_rdata=0x00000022, rsp_valid in cycle N+2.
REQ-045 Case sb: addr=0x0000_0003, wdata=0x000000A5 -> be=1000, ram_wdata=0xA5A5A5A5.
REQ-046 Case misaligned lw: addr=0x0000_0002 -> err one cycle, ram_req never asserted, no rsp_valid.
REQ-047 Case TIMEOUT=4, no ack -> err after 4 ACCESS cycles, back to IDLE; a repeat with ack in the 4th cycle -> rsp_valid, no err.
REQ-048 Case Reset_n=0 during ACCESS -> ram_req=0 next cycle, req_ready=1, no rsp_valid.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller: FSM states,
// byte-lane constants and the registered request record.
package dmem_pkg;

  localparam int ADDR_W_DEFAULT  = 10;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int DATA_W          = 32;
  localparam int LANE_W          = 2;
  localparam int BE_W            = 4;

  localparam logic [BE_W-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // Everything captured from the core when a request is accepted, except the
  // address, whose width depends on the RAM size.
  typedef struct packed {
    logic              we;
    logic              is_byte;
    logic [LANE_W-1:0] lane;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic [BE_W-1:0] lane_be(input logic [LANE_W-1:0] lane);
    return BE_W'(1) << lane;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bundle of the core-side request/response signals and the RAM-side port of
// the data-memory controller.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 10
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              stall;
  logic              err;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic              ram_ack;
  logic [31:0]       ram_rdata;

  // The controller side.
  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata, ram_ack, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, stall, err,
           ram_req, ram_we, ram_addr, ram_be, ram_wdata
  );

  // The core plus RAM model driving the controller.
  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata, ram_ack, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, stall, err,
           ram_req, ram_we, ram_addr, ram_be, ram_wdata
  );

endinterface

// File: rtl/dmem_ctrl_byte_lane.sv
// Byte-lane steering: store-side byte enables and write-data replication,
// load-side lane extraction with zero extension.
module byte_lane
  import dmem_pkg::*;
(
  input  logic [LANE_W-1:0] st_lane_i,
  input  logic              st_byte_i,
  input  logic [DATA_W-1:0] st_wdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [LANE_W-1:0] ld_lane_i,
  input  logic              ld_byte_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] ldata_o
);

  logic [7:0] lane_byte;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    be_o      = BE_ALL;
    wdata_o   = st_wdata_i;
    lane_byte = rdata_i[{ld_lane_i, 3'b000} +: 8];
    ldata_o   = rdata_i;
    if (st_byte_i) begin
      be_o    = lane_be(st_lane_i);
      wdata_o = {4{st_wdata_i[7:0]}};
    end
    if (ld_byte_i) begin
      ldata_o = {24'b0, lane_byte};
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage data-memory controller: accepts one load/store from the core,
// runs a single RAM handshake with timeout, and returns a one-cycle response.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic       clk,
  input logic       Reset_n,
  dmem_ctrl_if.slave bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [BE_W-1:0]   st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;
  logic              misaligned;
  logic              unused_addr_hi;

  byte_lane u_byte_lane (
    .st_lane_i (bus.req_addr[1:0]),
    .st_byte_i (bus.req_byte),
    .st_wdata_i(bus.req_wdata),
    .be_o      (st_be),
    .wdata_o   (st_wdata),
    .ld_lane_i (req_q.lane),
    .ld_byte_i (req_q.is_byte),
    .rdata_i   (bus.ram_rdata),
    .ldata_o   (ld_data)
  );

  assign misaligned     = !bus.req_byte && (bus.req_addr[1:0] != 2'b00);
  assign cnt_inc        = cnt_q + CNT_W'(1);
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          req_d.we      = bus.req_we;
          req_d.is_byte = bus.req_byte;
          req_d.lane    = bus.req_addr[1:0];
          req_d.be      = st_be;
          req_d.wdata   = st_wdata;
          addr_d        = bus.req_addr[ADDR_W+1:2];
          cnt_d         = '0;
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (bus.ram_ack) begin
          rdata_d = req_q.we ? '0 : ld_data;
          state_d = S_RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: every register is reset here, including the request record,
    // because the RAM-side outputs are required to read zero after reset.
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.stall     = ((state_q == S_IDLE) && bus.req_valid) || (state_q == S_ACCESS);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.err       = err_q;
  assign bus.ram_req   = (state_q == S_ACCESS);
  assign bus.ram_we    = req_q.we;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_be    = req_q.be;
  assign bus.ram_wdata = req_q.wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table driving a RAM model, with a
// response scoreboard and hand-written reset / ignore sequences.
module tb_dmem_ctrl;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stall_cyc = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  // d: cycle of ACCESS in which ack is given; 0 = never (timeout); -1 = misaligned.
  typedef struct {
    logic        we;
    logic        is_byte;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          d;
    bit          hold;
    logic [9:0]  exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          is_err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid/err must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.stall === 1'b1) stall_cyc++;
      if (bus.rsp_valid === 1'b1 || bus.err === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp_err", 32'({bus.rsp_valid, bus.err}), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rsp_valid", 32'(bus.rsp_valid), 32'(!e.is_err));
          check("err", 32'(bus.err), 32'(e.is_err));
          check("rsp_cycle", cyc, e.cyc);
          if (e.is_err) begin
            check("ram_req_on_err", 32'(bus.ram_req), 32'd0);
          end else begin
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("stall_in_resp", 32'(bus.stall), 32'd0);
          end
        end
      end
    end
  end

  task automatic apply(input vec_t v, input int idx);
    int   n;
    int   c;
    exp_t e;
    n = (v.d > 0) ? v.d : ((v.d == 0) ? TIMEOUT : 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_byte  = v.is_byte;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    c = cyc;
    stall_cyc = 0;
    e.is_err = (v.d <= 0);
    e.rdata  = v.exp_rdata;
    e.cyc    = c + n + 1;
    sb_q.push_back(e);
    @(negedge clk);
    check($sformatf("v%0d_ready_idle", idx), 32'(bus.req_ready), 32'd1);
    check($sformatf("v%0d_stall_req", idx), 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = v.hold;
    if (v.hold) begin
      bus.req_addr  = 32'hFFFF_FFF2;
      bus.req_wdata = ~v.wdata;
    end
    for (int k = 1; k <= n; k++) begin
      bus.ram_ack   = (k == v.d);
      bus.ram_rdata = (k == v.d) ? v.rdata : 32'hFFFF_FFFF;
      @(negedge clk);
      check($sformatf("v%0d_c%0d_ram_req", idx, k), 32'(bus.ram_req), 32'd1);
      check($sformatf("v%0d_c%0d_ram_we", idx, k), 32'(bus.ram_we), 32'(v.we));
      check($sformatf("v%0d_c%0d_ram_addr", idx, k), 32'(bus.ram_addr), 32'(v.exp_addr));
      check($sformatf("v%0d_c%0d_ram_be", idx, k), 32'(bus.ram_be), 32'(v.exp_be));
      check($sformatf("v%0d_c%0d_ram_wdata", idx, k), bus.ram_wdata, v.exp_wdata);
      check($sformatf("v%0d_c%0d_ready", idx, k), 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      bus.ram_ack   = 1'b0;
      bus.req_valid = 1'b0;
    end
    if (n == 0) begin
      @(negedge clk);
      check($sformatf("v%0d_no_ram_req", idx), 32'(bus.ram_req), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("v%0d_sb_drained", idx), sb_q.size(), 32'd0);
    check($sformatf("v%0d_stall_cycles", idx), stall_cyc, n + 1);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we  byte addr            wdata          rdata          d  hold addr    be    exp_wdata      exp_rdata
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h5555_5555, 3, 1'b1, 10'h002, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0006, 32'h0000_0000, 32'h1122_3344, 1, 1'b0, 10'h001, 4'h4, 32'h0000_0000, 32'h0000_0022};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0003, 32'h0000_00A5, 32'h5555_5555, 2, 1'b0, 10'h000, 4'h8, 32'hA5A5_A5A5, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, -1, 1'b0, 10'h000, 4'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'hCAFE_F00D, 1, 1'b0, 10'h004, 4'hF, 32'h1234_5678, 32'hCAFE_F00D};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0001, 32'h1234_567F, 32'h8899_AABB, 2, 1'b0, 10'h000, 4'h2, 32'h7F7F_7F7F, 32'h0000_00AA};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 10'h008, 4'hF, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_0024, 32'h0000_0000, 32'h0BAD_F00D, 4, 1'b1, 10'h009, 4'hF, 32'h0, 32'h0BAD_F00D};
    vecs[8]  = '{1'b1, 1'b1, 32'hFFFF_0FFC, 32'h0000_003C, 32'h5555_5555, 1, 1'b0, 10'h3FF, 4'h1, 32'h3C3C_3C3C, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, -1, 1'b0, 10'h000, 4'h0, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0107, 32'h0000_0000, 32'hF0E0_D0C0, 3, 1'b0, 10'h041, 4'h8, 32'h0, 32'h0000_00F0};

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_ram_req", 32'(bus.ram_req), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_ram_be", 32'(bus.ram_be), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i], i);
    end

    // ram_ack while idle must not produce a response.
    @(posedge clk); #1;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h1357_9BDF;
    repeat (3) begin
      @(negedge clk);
      check("idle_ack_ready", 32'(bus.req_ready), 32'd1);
      check("idle_ack_ram_req", 32'(bus.ram_req), 32'd0);
    end
    @(posedge clk); #1;
    bus.ram_ack = 1'b0;

    // Reset while waiting on the RAM drops the request with no response.
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = 32'h0000_0040;
    bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstacc_ram_req_before", 32'(bus.ram_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstacc_ram_req", 32'(bus.ram_req), 32'd0);
    check("rstacc_ready", 32'(bus.req_ready), 32'd1);
    check("rstacc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstacc_err", 32'(bus.err), 32'd0);
    check("rstacc_ram_addr", 32'(bus.ram_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Normal operation resumes after the mid-access reset.
    apply(vecs[1], 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
